// File: rtl/debug_cmd_queue.sv
// debug_cmd_queue
//   Moves debug commands from the TCK domain into clk. The vs_udr and vs_uir
//   levels are synchronised and edge-detected. Each vs_udr rising edge
//   pushes {ir_in, sr} into a small FIFO. When action_ready is high the head
//   entry is popped: jdo takes its SR field, and one one-hot strobe pulses
//   for one cycle. That strobe is take_action[ir] or take_no_action[ir],
//   selected by sr[ACTION_BIT].
//
//   Ports
//     clk, reset_n            system clock, async active-low reset
//     ir_in [IR_W], sr [SR_W] command payload, stable while vs_udr is high
//     vs_udr, vs_uir          asynchronous update levels from the TCK domain
//     action_ready            consumer accepts the head command this cycle
//     overflow_clr            clears overflow (and drop_count)
//     jdo [SR_W]              SR field of the last popped command
//     take_action, take_no_action [2**IR_W]  one-cycle one-hot strobes
//     cmd_pending, fifo_level queue status
//     ir_update               one pulse per synchronised vs_uir rising edge
//     overflow                sticky flag: a command was dropped
//     drop_count [8]          saturating drop counter
//
//   Build option: define DEBUG_CMD_QUEUE_DROPCNT_EN to include the drop
//   counter. Without it, drop_count is tied to zero.
module debug_cmd_queue #(
  parameter int SR_W        = 38,
  parameter int IR_W        = 2,
  parameter int DEPTH       = 4,
  parameter int SYNC_STAGES = 3,
  parameter int ACTION_BIT  = SR_W - 3
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [IR_W-1:0]          ir_in,
  input  logic [SR_W-1:0]          sr,
  input  logic                     vs_udr,
  input  logic                     vs_uir,
  input  logic                     action_ready,
  input  logic                     overflow_clr,
  output logic [SR_W-1:0]          jdo,
  output logic [2**IR_W-1:0]       take_action,
  output logic [2**IR_W-1:0]       take_no_action,
  output logic                     cmd_pending,
  output logic [$clog2(DEPTH):0]   fifo_level,
  output logic                     ir_update,
  output logic                     overflow,
  output logic [7:0]               drop_count
);

  localparam int NCH = 2**IR_W;
  localparam int AW  = $clog2(DEPTH);
  localparam int LW  = AW + 1;

  logic [SYNC_STAGES-1:0] udr_sync_q, uir_sync_q;
  logic                   udr_prev_q, uir_prev_q;

  logic [IR_W-1:0]        ir_mem_q [DEPTH];
  logic [SR_W-1:0]        sr_mem_q [DEPTH];
  logic [AW-1:0]          wr_ptr_q, rd_ptr_q;
  logic [LW-1:0]          level_q, level_d;

  logic [SR_W-1:0]        jdo_q;
  logic [NCH-1:0]         ta_q, ta_d, tna_q, tna_d;
  logic                   iru_q, ovf_q;

  logic udr_rise, uir_rise, full, pop, push, drop;
  logic [IR_W-1:0] head_ir;
  logic [SR_W-1:0] head_sr;

  assign udr_rise = udr_sync_q[SYNC_STAGES-1] & ~udr_prev_q;
  assign uir_rise = uir_sync_q[SYNC_STAGES-1] & ~uir_prev_q;

  // Pop decisions use the registered level, so an entry written into an
  // empty queue cannot be popped on its own write edge.
  assign full = (level_q == LW'(DEPTH));
  assign pop  = (level_q != '0) & action_ready;
  // A pop on the same edge frees a slot, so a full queue still accepts.
  assign push = udr_rise & (~full | pop);
  assign drop = udr_rise & full & ~pop;

  assign head_ir = ir_mem_q[rd_ptr_q];
  assign head_sr = sr_mem_q[rd_ptr_q];

  always_comb begin
    level_d = level_q;
    case ({push, pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
  end

  always_comb begin
    ta_d  = '0;
    tna_d = '0;
    if (pop) begin
      if (head_sr[ACTION_BIT]) ta_d[head_ir]  = 1'b1;
      else                     tna_d[head_ir] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      udr_sync_q <= '0;
      uir_sync_q <= '0;
      udr_prev_q <= 1'b0;
      uir_prev_q <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      jdo_q      <= '0;
      ta_q       <= '0;
      tna_q      <= '0;
      iru_q      <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      udr_sync_q <= {udr_sync_q[SYNC_STAGES-2:0], vs_udr};
      uir_sync_q <= {uir_sync_q[SYNC_STAGES-2:0], vs_uir};
      udr_prev_q <= udr_sync_q[SYNC_STAGES-1];
      uir_prev_q <= uir_sync_q[SYNC_STAGES-1];
      level_q    <= level_d;
      ta_q       <= ta_d;
      tna_q      <= tna_d;
      iru_q      <= uir_rise;
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
        jdo_q    <= head_sr;
      end
      if (drop)              ovf_q <= 1'b1;
      else if (overflow_clr) ovf_q <= 1'b0;
    end
  end

  // Payload storage needs no reset; the pointers and level define validity.
  always_ff @(posedge clk) begin
    if (push) begin
      ir_mem_q[wr_ptr_q] <= ir_in;
      sr_mem_q[wr_ptr_q] <= sr;
    end
  end

`ifdef DEBUG_CMD_QUEUE_DROPCNT_EN
  logic [7:0] drop_cnt_q;

  // A drop that coincides with a clear restarts the count at one.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      drop_cnt_q <= '0;
    end else if (drop) begin
      if (overflow_clr)              drop_cnt_q <= 8'd1;
      else if (drop_cnt_q != 8'hFF)  drop_cnt_q <= drop_cnt_q + 8'd1;
    end else if (overflow_clr) begin
      drop_cnt_q <= '0;
    end
  end

  assign drop_count = drop_cnt_q;
`else
  assign drop_count = 8'd0;
`endif

  assign jdo            = jdo_q;
  assign take_action    = ta_q;
  assign take_no_action = tna_q;
  assign cmd_pending    = (level_q != '0);
  assign fifo_level     = level_q;
  assign ir_update      = iru_q;
  assign overflow       = ovf_q;

endmodule

// File: tb/tb_debug_cmd_queue.sv
module tb_debug_cmd_queue;

  localparam int SR_W  = 38;
  localparam int IR_W  = 2;
  localparam int DEPTH = 4;
  localparam int SS    = 3;
  localparam int AB    = SR_W - 3;
  localparam int NCH   = 4;

  logic            clk = 1'b0;
  logic            reset_n;
  logic [IR_W-1:0] ir_in;
  logic [SR_W-1:0] sr;
  logic            vs_udr, vs_uir, action_ready, overflow_clr;
  logic [SR_W-1:0] jdo;
  logic [NCH-1:0]  take_action, take_no_action;
  logic            cmd_pending, ir_update, overflow;
  logic [2:0]      fifo_level;
  logic [7:0]      drop_count;

  debug_cmd_queue #(
    .SR_W(SR_W), .IR_W(IR_W), .DEPTH(DEPTH), .SYNC_STAGES(SS), .ACTION_BIT(AB)
  ) dut (
    .clk(clk), .reset_n(reset_n), .ir_in(ir_in), .sr(sr),
    .vs_udr(vs_udr), .vs_uir(vs_uir), .action_ready(action_ready),
    .overflow_clr(overflow_clr), .jdo(jdo), .take_action(take_action),
    .take_no_action(take_no_action), .cmd_pending(cmd_pending),
    .fifo_level(fifo_level), .ir_update(ir_update), .overflow(overflow),
    .drop_count(drop_count)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Commands live in a queue; a vs_udr/vs_uir rising edge is seen SS edges
  // after the level first appears at a clock edge.
  typedef struct packed {
    logic [IR_W-1:0] ir;
    logic [SR_W-1:0] sr;
  } cmd_t;

  cmd_t            mq[$];
  cmd_t            m_h;
  logic [SR_W-1:0] m_jdo = '0;
  logic [NCH-1:0]  m_ta = '0, m_tna = '0;
  logic            m_iru = 1'b0, m_ovf = 1'b0;
  int              m_dcnt = 0;
  logic [7:0]      udr_h = '0, uir_h = '0;
  bit              m_rise, m_pop, m_drop;

  always @(posedge clk) begin
    if (!reset_n) begin
      mq.delete();
      m_jdo = '0; m_ta = '0; m_tna = '0; m_iru = 1'b0; m_ovf = 1'b0;
      m_dcnt = 0; udr_h = '0; uir_h = '0;
    end else begin
      udr_h  = {udr_h[6:0], vs_udr};
      uir_h  = {uir_h[6:0], vs_uir};
      m_rise = udr_h[SS] & ~udr_h[SS+1];
      m_iru  = uir_h[SS] & ~uir_h[SS+1];
      m_pop  = (mq.size() > 0) && action_ready;
      m_drop = 1'b0;
      m_ta   = '0;
      m_tna  = '0;
      if (m_pop) begin
        m_h   = mq.pop_front();
        m_jdo = m_h.sr;
        if (m_h.sr[AB]) m_ta[m_h.ir] = 1'b1;
        else            m_tna[m_h.ir] = 1'b1;
      end
      if (m_rise) begin
        if (mq.size() < DEPTH) mq.push_back(cmd_t'({ir_in, sr}));
        else                   m_drop = 1'b1;
      end
      if (m_drop) begin
        m_ovf  = 1'b1;
        m_dcnt = overflow_clr ? 1 : ((m_dcnt < 255) ? m_dcnt + 1 : 255);
      end else if (overflow_clr) begin
        m_ovf  = 1'b0;
        m_dcnt = 0;
      end
    end
    #1;
    check("m_jdo", jdo, m_jdo);
    check("m_take_action", take_action, m_ta);
    check("m_take_no_action", take_no_action, m_tna);
    check("m_cmd_pending", cmd_pending, mq.size() != 0);
    check("m_fifo_level", fifo_level, mq.size());
    check("m_ir_update", ir_update, m_iru);
    check("m_overflow", overflow, m_ovf);
`ifdef DEBUG_CMD_QUEUE_DROPCNT_EN
    check("m_drop_count", drop_count, m_dcnt);
`else
    check("m_drop_count", drop_count, 0);
`endif
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic pulse(input logic [IR_W-1:0] ir, input logic [SR_W-1:0] d);
    ir_in = ir; sr = d; vs_udr = 1'b1;
    tick(); tick();
    vs_udr = 1'b0;
    tick(); tick();
  endtask

  task automatic wait_strobe(input int budget, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if ((|take_action) || (|take_no_action)) begin
        seen = 1'b1;
        return;
      end
      tick();
    end
  endtask

  typedef struct {
    logic [IR_W-1:0] ir;
    logic [SR_W-1:0] sr;
    logic [NCH-1:0]  ta;
    logic [NCH-1:0]  tna;
  } vec_t;

  vec_t vt[5];
  logic [SR_W-1:0] exp_seq[4];
  bit   seen;
  int   idx, cnt;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, n_cmp=%0d", n_cmp);
    $fatal(1, "watchdog");
  end

  initial begin
    // Bit 35 is the action bit at the default SR_W.
    vt[0] = '{2'd2, 38'h08_0000_00AB, 4'b0100, 4'b0000};
    vt[1] = '{2'd1, 38'h00_0000_1234, 4'b0000, 4'b0010};
    vt[2] = '{2'd3, 38'h3F_FFFF_FFFF, 4'b1000, 4'b0000};
    vt[3] = '{2'd0, 38'h37_0000_0001, 4'b0000, 4'b0001};
    vt[4] = '{2'd0, 38'h08_0000_0000, 4'b0001, 4'b0000};

    reset_n = 1'b0; ir_in = '0; sr = '0; vs_udr = 1'b0; vs_uir = 1'b0;
    action_ready = 1'b0; overflow_clr = 1'b0;
    tick(); tick();
    check("rst_jdo", jdo, 0);
    check("rst_cmd_pending", cmd_pending, 0);
    check("rst_fifo_level", fifo_level, 0);
    check("rst_strobes", {take_action, take_no_action}, 0);
    check("rst_overflow", overflow, 0);
    check("rst_drop_count", drop_count, 0);
    reset_n = 1'b1;
    tick();

    // single commands through the table
    action_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      pulse(vt[i].ir, vt[i].sr);
      wait_strobe(20, seen);
      check("tbl_strobe_seen", seen, 1);
      check("tbl_take_action", take_action, vt[i].ta);
      check("tbl_take_no_action", take_no_action, vt[i].tna);
      check("tbl_jdo", jdo, vt[i].sr);
      tick();
      check("tbl_strobe_width", {take_action, take_no_action}, 0);
      check("tbl_jdo_hold", jdo, vt[i].sr);
    end

    // overflow: five commands with the consumer stalled
    action_ready = 1'b0;
    for (int k = 1; k <= 5; k++) pulse(2'd1, SR_W'(k));
    tick(); tick(); tick();
    check("ovf_level", fifo_level, 4);
    check("ovf_flag", overflow, 1);
`ifdef DEBUG_CMD_QUEUE_DROPCNT_EN
    check("ovf_drop_count", drop_count, 1);
`else
    check("ovf_drop_count", drop_count, 0);
`endif
    action_ready = 1'b1;
    idx = 0;
    for (int c = 0; c < 20; c++) begin
      if ((|take_action) || (|take_no_action)) begin
        check("ovf_drain_jdo", jdo, idx + 1);
        idx++;
      end
      tick();
    end
    check("ovf_drain_count", idx, 4);
    overflow_clr = 1'b1;
    tick();
    overflow_clr = 1'b0;
    check("ovf_cleared", overflow, 0);
    check("ovf_cnt_cleared", drop_count, 0);

    // full queue, write detected on the same edge as a pop
    action_ready = 1'b0;
    for (int k = 0; k < 4; k++) pulse(2'd0, SR_W'(17 + k));
    check("wp_full", fifo_level, 4);
    ir_in = 2'd3; sr = 38'h99; vs_udr = 1'b1;
    tick(); tick(); tick();
    action_ready = 1'b1;
    tick();
    check("wp_level", fifo_level, 4);
    check("wp_overflow", overflow, 0);
    action_ready = 1'b0; vs_udr = 1'b0;
    tick();
    exp_seq[0] = 38'd18; exp_seq[1] = 38'd19; exp_seq[2] = 38'd20; exp_seq[3] = 38'h99;
    action_ready = 1'b1;
    idx = 0;
    for (int c = 0; c < 20; c++) begin
      if (((|take_action) || (|take_no_action)) && idx < 4) begin
        check("wp_drain_jdo", jdo, exp_seq[idx]);
        idx++;
      end
      tick();
    end
    check("wp_drain_count", idx, 4);

    // reset with entries queued
    action_ready = 1'b0;
    for (int k = 0; k < 3; k++) pulse(2'd2, SR_W'(40 + k) | (38'd1 << AB));
    check("rq_level", fifo_level, 3);
    reset_n = 1'b0;
    tick();
    check("rq_pending", cmd_pending, 0);
    check("rq_fifo_level", fifo_level, 0);
    reset_n = 1'b1;
    action_ready = 1'b1;
    cnt = 0;
    for (int c = 0; c < 12; c++) begin
      tick();
      if ((|take_action) || (|take_no_action)) cnt++;
    end
    check("rq_no_strobes", cnt, 0);

    // vs_udr held high across reset release
    action_ready = 1'b0;
    reset_n = 1'b0; ir_in = 2'd1; sr = 38'd5; vs_udr = 1'b1;
    tick(); tick();
    reset_n = 1'b1;
    for (int c = 0; c < 10; c++) tick();
    check("rh_one_capture", fifo_level, 1);
    vs_udr = 1'b0;
    tick(); tick(); tick();
    check("rh_still_one", fifo_level, 1);
    action_ready = 1'b1;
    tick(); tick(); tick();
    check("rh_drained", fifo_level, 0);

    // ir_update pulse leaves the queue alone
    action_ready = 1'b0;
    pulse(2'd0, 38'd7);
    tick();
    check("iu_level_before", fifo_level, 1);
    vs_uir = 1'b1;
    tick(); tick();
    vs_uir = 1'b0;
    cnt = 0;
    for (int c = 0; c < 10; c++) begin
      if (ir_update) cnt++;
      tick();
    end
    check("iu_pulse_count", cnt, 1);
    check("iu_level_after", fifo_level, 1);
    action_ready = 1'b1;
    tick(); tick(); tick();

    // randomized traffic checked by the model every cycle
    for (int c = 0; c < 3000; c++) begin
      if (!vs_udr && $urandom_range(0, 3) == 0) begin
        ir_in  = IR_W'($urandom());
        sr     = SR_W'({$urandom(), $urandom()});
        vs_udr = 1'b1;
      end else if (vs_udr && $urandom_range(0, 2) == 0) begin
        vs_udr = 1'b0;
      end
      if ($urandom_range(0, 4) == 0) vs_uir = ~vs_uir;
      action_ready = ($urandom_range(0, 9) < 5);
      overflow_clr = ($urandom_range(0, 15) == 0);
      reset_n      = ($urandom_range(0, 799) != 0);
      tick();
    end
    reset_n = 1'b1; vs_udr = 1'b0; vs_uir = 1'b0; overflow_clr = 1'b0;
    action_ready = 1'b1;
    for (int c = 0; c < 10; c++) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
